// File: rtl/jkff_active_low_pkg.sv
// Shared JK command encoding and next-state helper
// for the jkff_active_low flip-flop bank.
package jkff_active_low_pkg;

    // JK commands, indexed as {J,K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Next-state bit from the {J,K} command and the current Q.
    // An unknown command yields X so bad inputs stay visible.
    function automatic logic jk_next(
        input logic [1:0] jk,
        input logic       q
    );
        logic nxt;
        case (jk)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TOG:  nxt = ~q;
            default: nxt = 1'bx;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jkff_bit.sv
// Single-bit JK register with synchronous reset to RESET_VAL.
// Optional complement register when JKFF_QN_EN is defined.
module jkff_bit
    import jkff_active_low_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
`ifdef JKFF_QN_EN
    ,
    output logic qn
`endif
);

    // Q register: reset dominates, otherwise JK characteristic
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= jk_next({j, k}, q);
        end
    end

`ifdef JKFF_QN_EN
    // Independent complement register, always ~Q after each edge
    always_ff @(posedge clk) begin
        if (reset) begin
            qn <= ~RESET_VAL;
        end else begin
            qn <= ~jk_next({j, k}, q);
        end
    end
`endif

endmodule

// File: rtl/jkff_active_low.sv
// Bank of WIDTH independent JK flip-flops, synchronous active-high reset.
// Define JKFF_QN_EN to add the registered complement output qn.
module jkff_active_low
    import jkff_active_low_pkg::*;
#(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    input  logic             reset
`ifdef JKFF_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    // One flip-flop per bit; no cross-bit interaction
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jkff_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .j     (J[i]),
            .k     (K[i]),
            .q     (Q[i])
`ifdef JKFF_QN_EN
            ,
            .qn    (qn[i])
`endif
        );
    end

endmodule

// File: tb/tb_jkff_active_low.sv
// Self-checking bench: directed 1-bit sequence plus randomized
// 4-bit bank checked against a per-bit JK reference model.
module tb_jkff_active_low;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk = 1'b0;
    logic       j1, k1, r1;
    logic       q1;
    logic [3:0] j4, k4;
    logic       r4;
    logic [3:0] q4;
    logic [3:0] m4;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef JKFF_QN_EN
    logic       qn1;
    logic [3:0] qn4;
`endif

    always #5 clk = ~clk;

    jkff_active_low u_dut1 (
        .J     (j1),
        .K     (k1),
        .clk   (clk),
        .Q     (q1),
        .reset (r1)
`ifdef JKFF_QN_EN
        ,
        .qn    (qn1)
`endif
    );

    jkff_active_low #(
        .WIDTH     (4),
        .RESET_VAL (RV4)
    ) u_dut4 (
        .J     (j4),
        .K     (k4),
        .clk   (clk),
        .Q     (q4),
        .reset (r4)
`ifdef JKFF_QN_EN
        ,
        .qn    (qn4)
`endif
    );

    // Reference: JK characteristic per bit, reset dominates
    function automatic logic [3:0] ref_next(
        input logic [3:0] q,
        input logic [3:0] j,
        input logic [3:0] k,
        input logic       r
    );
        logic [3:0] n;
        if (r) return RV4;
        for (int i = 0; i < 4; i++) begin
            if (j[i] && k[i])  n[i] = ~q[i];
            else if (j[i])     n[i] = 1'b1;
            else if (k[i])     n[i] = 1'b0;
            else               n[i] = q[i];
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string      tag,
        input logic [3:0] obs,
        input logic [3:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step4(input string tag);
        m4 = ref_next(m4, j4, k4, r4);
        tick();
        chk(tag, q4, m4);
`ifdef JKFF_QN_EN
        chk({tag, "_qn"}, qn4, ~m4);
`endif
    endtask

    initial begin
        // 4-bit bank held in reset during the 1-bit phase
        r4 = 1'b1;
        j4 = 4'b0000;
        k4 = 4'b0000;

        // No-reset start
        r1 = 1'b0; j1 = 1'b0; k1 = 1'b1;
        tick(); chk("nrst_clr", {3'b0, q1}, 4'd0);
        j1 = 1'b1; k1 = 1'b0;
        tick(); chk("nrst_set", {3'b0, q1}, 4'd1);
        j1 = 1'b1; k1 = 1'b1;
        tick(); chk("nrst_tog", {3'b0, q1}, 4'd0);

        // Reset dominates toggle
        r1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
        tick(); chk("rst_e1", {3'b0, q1}, 4'd0);
        tick(); chk("rst_e2", {3'b0, q1}, 4'd0);
`ifdef JKFF_QN_EN
        chk("rst_qn", {3'b0, qn1}, 4'd1);
`endif

        // Set / clear / hold
        r1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
        tick(); chk("set", {3'b0, q1}, 4'd1);
        j1 = 1'b0; k1 = 1'b1;
        tick(); chk("clr", {3'b0, q1}, 4'd0);
        j1 = 1'b0; k1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold", {3'b0, q1}, 4'd0);
        end

        // Toggle 1,0,1,0
        j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tog", {3'b0, q1}, (i % 2 == 0) ? 4'd1 : 4'd0);
        end

        // Mid-operation reset
        tick(); chk("mid_pre", {3'b0, q1}, 4'd1);
        r1 = 1'b1;
        tick(); chk("mid_rst", {3'b0, q1}, 4'd0);
        r1 = 1'b0;
        tick(); chk("mid_rel", {3'b0, q1}, 4'd1);

        // 4-bit bank: reset value and complement
        r4 = 1'b1;
        m4 = 4'bxxxx;
        step4("w4_rst");
        r4 = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
        step4("w4_mix");

        // Input change between edges has no effect
        j4 = 4'b1111; k4 = 4'b0000;
        #3;
        chk("w4_noasync", q4, m4);
        j4 = 4'b0000;

        // Randomized stimulus against the model
        for (int i = 0; i < 60; i++) begin
            j4 = 4'($urandom);
            k4 = 4'($urandom);
            r4 = ($urandom_range(0, 7) == 0);
            step4("w4_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
